// File: rtl/elbeth_regfile_sb.sv
// =====================================================================
// elbeth_regfile_sb : GPR file with WB->ID bypass and pending-write scoreboard
// Rev 1.0
// =====================================================================
`default_nettype none

module elbeth_regfile_sb #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] id_rs1_addr,
   input  logic [ADDR_W-1:0] id_rs2_addr,
   output logic [XLEN-1:0]   id_rs1_data,
   output logic [XLEN-1:0]   id_rs2_data,
   output logic              id_rs1_busy,
   output logic              id_rs2_busy,
   output logic              id_stall,
   input  logic [ADDR_W-1:0] id_rd_addr,
   input  logic              id_rd_reserve,
   input  logic [ADDR_W-1:0] wb_rd_addr,
   input  logic [XLEN-1:0]   wb_rd_data,
   input  logic              wb_w_enable,
   input  logic              flush,
   output logic [ADDR_W:0]   pending_cnt
);

   localparam int c_nregs = 2**ADDR_W;

   logic [XLEN-1:0]  r_regs [c_nregs];
   logic [c_nregs-1:0] r_busy;
   logic [ADDR_W:0]  r_pending;

   logic             w_wb_valid;
   logic             w_rsv_valid;
   logic             w_rs1_hit;
   logic             w_rs2_hit;
   logic             w_inc;
   logic             w_dec;
   logic [c_nregs-1:0] w_busy_next;

   assign w_wb_valid  = wb_w_enable && (wb_rd_addr != '0);
   assign w_rsv_valid = id_rd_reserve && (id_rd_addr != '0);

   // Entry 0 is only ever loaded by reset, so it stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_nregs; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wb_valid) begin
         r_regs[wb_rd_addr] <= wb_rd_data;
      end
   end

   // Reserve is applied after writeback so the newer producer keeps the bit.
   always_comb begin
      w_busy_next = r_busy;
      if (w_wb_valid) begin
         w_busy_next[wb_rd_addr] = 1'b0;
      end
      if (w_rsv_valid) begin
         w_busy_next[id_rd_addr] = 1'b1;
      end
      if (flush) begin
         w_busy_next = '0;
      end
      w_busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   assign w_inc = w_rsv_valid && !r_busy[id_rd_addr];
   assign w_dec = w_wb_valid && r_busy[wb_rd_addr] &&
                  !(w_rsv_valid && (id_rd_addr == wb_rd_addr));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else if (flush) begin
         r_pending <= '0;
      end else if (w_inc && !w_dec) begin
         r_pending <= r_pending + 1'b1;
      end else if (w_dec && !w_inc) begin
         r_pending <= r_pending - 1'b1;
      end
   end

   // Bypass is gated by reset so reads are zero while held in reset.
   assign w_rs1_hit = (BYPASS != 0) && rst_n && wb_w_enable && (wb_rd_addr == id_rs1_addr);
   assign w_rs2_hit = (BYPASS != 0) && rst_n && wb_w_enable && (wb_rd_addr == id_rs2_addr);

   assign id_rs1_data = (id_rs1_addr == '0) ? '0 :
                        w_rs1_hit ? wb_rd_data : r_regs[id_rs1_addr];
   assign id_rs2_data = (id_rs2_addr == '0) ? '0 :
                        w_rs2_hit ? wb_rd_data : r_regs[id_rs2_addr];

   assign id_rs1_busy = r_busy[id_rs1_addr] && (id_rs1_addr != '0) && !w_rs1_hit;
   assign id_rs2_busy = r_busy[id_rs2_addr] && (id_rs2_addr != '0) && !w_rs2_hit;
   assign id_stall    = id_rs1_busy || id_rs2_busy;
   assign pending_cnt = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_elbeth_regfile_sb.sv
// =====================================================================
// tb_elbeth_regfile_sb : self-checking bench, bypass and non-bypass builds
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_elbeth_regfile_sb;

   logic        clk;
   logic        rst_n;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
   logic        id_rd_reserve, wb_w_enable, flush;
   logic [31:0] wb_rd_data;

   logic [31:0] rs1_data_b, rs2_data_b, rs1_data_n, rs2_data_n;
   logic        rs1_busy_b, rs2_busy_b, stall_b;
   logic        rs1_busy_n, rs2_busy_n, stall_n;
   logic [5:0]  pend_b, pend_n;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_regs [32];
   bit          m_busy [32];

   elbeth_regfile_sb #(.XLEN(32), .ADDR_W(5), .BYPASS(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_data(rs1_data_b), .id_rs2_data(rs2_data_b),
      .id_rs1_busy(rs1_busy_b), .id_rs2_busy(rs2_busy_b), .id_stall(stall_b),
      .id_rd_addr(id_rd_addr), .id_rd_reserve(id_rd_reserve),
      .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data), .wb_w_enable(wb_w_enable),
      .flush(flush), .pending_cnt(pend_b)
   );

   elbeth_regfile_sb #(.XLEN(32), .ADDR_W(5), .BYPASS(0)) dut_n (
      .clk(clk), .rst_n(rst_n),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_data(rs1_data_n), .id_rs2_data(rs2_data_n),
      .id_rs1_busy(rs1_busy_n), .id_rs2_busy(rs2_busy_n), .id_stall(stall_n),
      .id_rd_addr(id_rd_addr), .id_rd_reserve(id_rd_reserve),
      .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data), .wb_w_enable(wb_w_enable),
      .flush(flush), .pending_cnt(pend_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; wb_rd_addr = '0;
      id_rd_reserve = 1'b0; wb_w_enable = 1'b0; flush = 1'b0; wb_rd_data = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (pend_b !== 6'd0 || stall_b !== 1'b0 || rs1_data_b !== 32'd0) begin
         errors++;
         $display("FAIL reset_initial: pend=%0d stall=%0b rs1=%h, want 0/0/0", pend_b, stall_b, rs1_data_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      // populate some state, then reset in the middle of a cycle
      wb_w_enable = 1'b1; wb_rd_addr = 5'd5; wb_rd_data = 32'h1111_2222;
      id_rd_reserve = 1'b1; id_rd_addr = 5'd7;
      tick();
      wb_rd_addr = 5'd6; wb_rd_data = 32'h3333_4444; id_rd_addr = 5'd8;
      #2;
      rst_n = 1'b0;
      id_rs1_addr = 5'd5; id_rs2_addr = 5'd7;
      #1;
      checks++;
      if (rs1_data_b !== 32'd0 || rs1_data_n !== 32'd0) begin
         errors++;
         $display("FAIL reset_data: got %h/%h want 0", rs1_data_b, rs1_data_n);
      end
      checks++;
      if (pend_b !== 6'd0 || stall_b !== 1'b0 || stall_n !== 1'b0) begin
         errors++;
         $display("FAIL reset_sb: pend=%0d stall=%0b/%0b want 0/0/0", pend_b, stall_b, stall_n);
      end
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      idle();
      id_rs1_addr = 5'd6; id_rs2_addr = 5'd5;
      #1;
      checks++;
      if (rs1_data_n !== 32'd0 || rs2_data_n !== 32'd0 || pend_n !== 6'd0) begin
         errors++;
         $display("FAIL reset_nowrite: x6=%h x5=%h pend=%0d want 0/0/0", rs1_data_n, rs2_data_n, pend_n);
      end
      @(negedge clk);
   endtask

   task automatic test_write_read();
      idle();
      wb_w_enable = 1'b1; wb_rd_addr = 5'd5; wb_rd_data = 32'hDEAD_BEEF;
      tick();
      idle();
      id_rs1_addr = 5'd5;
      #1;
      checks++;
      if (rs1_data_b !== 32'hDEAD_BEEF || rs1_data_n !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL write_read_x5: got %h/%h want deadbeef", rs1_data_b, rs1_data_n);
      end
      @(negedge clk);
      wb_w_enable = 1'b1; wb_rd_addr = 5'd0; wb_rd_data = 32'h0000_1234;
      id_rs2_addr = 5'd0;
      #1;
      checks++;
      if (rs2_data_b !== 32'd0 || rs2_data_n !== 32'd0) begin
         errors++;
         $display("FAIL x0_bypass: got %h/%h want 0", rs2_data_b, rs2_data_n);
      end
      @(negedge clk);
      tick();
      idle();
      #1;
      checks++;
      if (rs2_data_b !== 32'd0 || pend_b !== 6'd0) begin
         errors++;
         $display("FAIL x0_write: got %h pend=%0d want 0/0", rs2_data_b, pend_b);
      end
      @(negedge clk);
   endtask

   task automatic test_bypass();
      idle();
      wb_w_enable = 1'b1; wb_rd_addr = 5'd7; wb_rd_data = 32'h0BAD_F00D;
      tick();
      idle();
      id_rd_reserve = 1'b1; id_rd_addr = 5'd7;
      tick();
      idle();
      wb_w_enable = 1'b1; wb_rd_addr = 5'd7; wb_rd_data = 32'hA5A5_A5A5;
      id_rs1_addr = 5'd7;
      #1;
      checks++;
      if (rs1_data_b !== 32'hA5A5_A5A5 || rs1_busy_b !== 1'b0 || stall_b !== 1'b0) begin
         errors++;
         $display("FAIL bypass_on: data=%h busy=%0b stall=%0b want a5a5a5a5/0/0", rs1_data_b, rs1_busy_b, stall_b);
      end
      checks++;
      if (rs1_data_n !== 32'h0BAD_F00D || rs1_busy_n !== 1'b1 || stall_n !== 1'b1) begin
         errors++;
         $display("FAIL bypass_off: data=%h busy=%0b stall=%0b want 0badf00d/1/1", rs1_data_n, rs1_busy_n, stall_n);
      end
      @(negedge clk);
      tick();
      wb_w_enable = 1'b0;
      #1;
      checks++;
      if (rs1_data_n !== 32'hA5A5_A5A5 || pend_n !== 6'd0 || rs1_busy_n !== 1'b0) begin
         errors++;
         $display("FAIL bypass_commit: data=%h pend=%0d busy=%0b want a5a5a5a5/0/0", rs1_data_n, pend_n, rs1_busy_n);
      end
      @(negedge clk);
   endtask

   task automatic test_scoreboard();
      idle();
      id_rd_reserve = 1'b1; id_rd_addr = 5'd3;
      tick();
      idle();
      id_rs2_addr = 5'd3;
      #1;
      checks++;
      if (rs2_busy_b !== 1'b1 || stall_b !== 1'b1 || pend_b !== 6'd1) begin
         errors++;
         $display("FAIL sb_reserve: busy=%0b stall=%0b pend=%0d want 1/1/1", rs2_busy_b, stall_b, pend_b);
      end
      @(negedge clk);
      wb_w_enable = 1'b1; wb_rd_addr = 5'd3; wb_rd_data = 32'h0000_0033;
      tick();
      wb_w_enable = 1'b0;
      #1;
      checks++;
      if (rs2_busy_b !== 1'b0 || stall_n !== 1'b0 || pend_b !== 6'd0 || pend_n !== 6'd0) begin
         errors++;
         $display("FAIL sb_release: busy=%0b stall=%0b pend=%0d/%0d want 0/0/0/0", rs2_busy_b, stall_n, pend_b, pend_n);
      end
      @(negedge clk);
   endtask

   task automatic test_simultaneous();
      idle();
      id_rd_reserve = 1'b1; id_rd_addr = 5'd9;
      tick();
      wb_w_enable = 1'b1; wb_rd_addr = 5'd9; wb_rd_data = 32'h1234_5678;
      tick();
      idle();
      id_rs1_addr = 5'd9;
      #1;
      checks++;
      if (rs1_busy_b !== 1'b1 || rs1_data_b !== 32'h1234_5678 || pend_b !== 6'd1) begin
         errors++;
         $display("FAIL sim_same: busy=%0b data=%h pend=%0d want 1/12345678/1", rs1_busy_b, rs1_data_b, pend_b);
      end
      @(negedge clk);
      id_rd_reserve = 1'b1; id_rd_addr = 5'd4;
      wb_w_enable = 1'b1; wb_rd_addr = 5'd9; wb_rd_data = 32'h9999_0000;
      tick();
      idle();
      id_rs1_addr = 5'd9; id_rs2_addr = 5'd4;
      #1;
      checks++;
      if (pend_b !== 6'd1 || rs1_busy_n !== 1'b0 || rs2_busy_n !== 1'b1) begin
         errors++;
         $display("FAIL sim_diff: pend=%0d b9=%0b b4=%0b want 1/0/1", pend_b, rs1_busy_n, rs2_busy_n);
      end
      @(negedge clk);
      wb_w_enable = 1'b1; wb_rd_addr = 5'd4; wb_rd_data = 32'h0000_0044;
      tick();
      idle();
   endtask

   task automatic test_flush();
      idle();
      for (int r = 1; r < 32; r++) begin
         id_rd_reserve = 1'b1; id_rd_addr = 5'(r);
         tick();
      end
      idle();
      #1;
      checks++;
      if (pend_b !== 6'd31 || pend_n !== 6'd31) begin
         errors++;
         $display("FAIL flush_full: pend=%0d/%0d want 31", pend_b, pend_n);
      end
      @(negedge clk);
      flush = 1'b1; id_rd_reserve = 1'b1; id_rd_addr = 5'd2;
      tick();
      idle();
      id_rs1_addr = 5'd2; id_rs2_addr = 5'd31;
      #1;
      checks++;
      if (pend_b !== 6'd0 || stall_b !== 1'b0 || stall_n !== 1'b0) begin
         errors++;
         $display("FAIL flush_clear: pend=%0d stall=%0b/%0b want 0/0/0", pend_b, stall_b, stall_n);
      end
      @(negedge clk);
      id_rs1_addr = 5'd5; id_rs2_addr = 5'd9;
      #1;
      checks++;
      if (rs1_data_b !== 32'hDEAD_BEEF || rs2_data_b !== 32'h9999_0000) begin
         errors++;
         $display("FAIL flush_contents: x5=%h x9=%h want deadbeef/99990000", rs1_data_b, rs2_data_b);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [31:0] got_d1, got_d2, exp_d1, exp_d2;
      logic        got_b1, got_b2, got_st, exp_b1, exp_b2, hit1, hit2;
      logic [5:0]  got_p;
      int          exp_p;
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = '0;
         m_busy[r] = 1'b0;
      end
      for (int n = 0; n < 600; n++) begin
         id_rs1_addr   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         id_rs2_addr   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         id_rd_addr    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         wb_rd_addr    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         id_rd_reserve = ($urandom_range(0, 2) == 0);
         wb_w_enable   = ($urandom_range(0, 1) != 0);
         wb_rd_data    = $urandom;
         flush         = ($urandom_range(0, 40) == 0);
         #1;
         exp_p = 0;
         for (int r = 0; r < 32; r++) exp_p += int'(m_busy[r]);
         for (int b = 0; b < 2; b++) begin
            got_d1 = (b != 0) ? rs1_data_b : rs1_data_n;
            got_d2 = (b != 0) ? rs2_data_b : rs2_data_n;
            got_b1 = (b != 0) ? rs1_busy_b : rs1_busy_n;
            got_b2 = (b != 0) ? rs2_busy_b : rs2_busy_n;
            got_st = (b != 0) ? stall_b : stall_n;
            got_p  = (b != 0) ? pend_b : pend_n;
            hit1 = (b != 0) && wb_w_enable && (wb_rd_addr == id_rs1_addr);
            hit2 = (b != 0) && wb_w_enable && (wb_rd_addr == id_rs2_addr);
            exp_d1 = (id_rs1_addr == 0) ? 32'd0 : (hit1 ? wb_rd_data : m_regs[id_rs1_addr]);
            exp_d2 = (id_rs2_addr == 0) ? 32'd0 : (hit2 ? wb_rd_data : m_regs[id_rs2_addr]);
            exp_b1 = m_busy[id_rs1_addr] && (id_rs1_addr != 0) && !hit1;
            exp_b2 = m_busy[id_rs2_addr] && (id_rs2_addr != 0) && !hit2;
            checks++;
            if (got_d1 !== exp_d1 || got_d2 !== exp_d2) begin
               errors++;
               $display("FAIL rand_data bypass=%0d cyc=%0d: got %h/%h want %h/%h", b, n, got_d1, got_d2, exp_d1, exp_d2);
            end
            checks++;
            if (got_b1 !== exp_b1 || got_b2 !== exp_b2 || got_st !== (exp_b1 | exp_b2)) begin
               errors++;
               $display("FAIL rand_busy bypass=%0d cyc=%0d: got %0b%0b/%0b want %0b%0b/%0b", b, n, got_b1, got_b2, got_st, exp_b1, exp_b2, exp_b1 | exp_b2);
            end
            checks++;
            if (int'(got_p) != exp_p) begin
               errors++;
               $display("FAIL rand_pending bypass=%0d cyc=%0d: got %0d want %0d", b, n, got_p, exp_p);
            end
         end
         @(posedge clk);
         if (flush) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
         end else begin
            if (wb_w_enable && wb_rd_addr != 0) m_busy[wb_rd_addr] = 1'b0;
            if (id_rd_reserve && id_rd_addr != 0) m_busy[id_rd_addr] = 1'b1;
         end
         if (wb_w_enable && wb_rd_addr != 0) m_regs[wb_rd_addr] = wb_rd_data;
         @(negedge clk);
      end
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      test_reset();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_simultaneous();
      test_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
